// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Desc   : UART receive sequencer that samples each bit at mid-period and
//          drives an external shift register and FIFO. Define
//          UART_RX_PARITY_EN to add an even-parity bit (8E1) to the frame.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int CLK_DIV = 868
) (
    input  logic Clk,
    input  logic Rst,
    input  logic RxD,
    input  logic Fifo_full,
    output logic Shift_ena,
    output logic Shift_din,
    output logic Data_valid,
    output logic Busy,
    output logic Frame_err,
    output logic Overrun_err,
    output logic Parity_err
);

    localparam int c_cnt_w = $clog2(CLK_DIV);

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLK_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero  = '0;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_parity = 3'd3;
`endif
    localparam logic [2:0] c_stop   = 3'd4;

    logic [1:0]         r_sync;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_cnt;

    logic w_rx_s;
    logic w_sample;
    logic w_stop_sample;
    logic w_good_stop;
    logic w_par_err;

    assign w_rx_s = r_sync[1];

    // The start bit is sampled half a period in; every later bit one full period on.
    always_comb begin
        w_sample = 1'b0;
        if (r_state == c_start) begin
            w_sample = (r_baud_cnt == c_half_last);
        end else if (r_state != c_idle) begin
            w_sample = (r_baud_cnt == c_bit_last);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_acc;
    logic r_par_err;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_par_acc <= 1'b0;
            r_par_err <= 1'b0;
        end else if (r_state == c_start) begin
            r_par_acc <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_sample && (r_state == c_data)) begin
            r_par_acc <= r_par_acc ^ w_rx_s;
        end else if (w_sample && (r_state == c_parity)) begin
            r_par_err <= r_par_acc ^ w_rx_s;
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync     <= 2'b11;
            r_state    <= c_idle;
            r_baud_cnt <= c_cnt_zero;
            r_bit_cnt  <= 3'd0;
        end else begin
            r_sync <= {r_sync[0], RxD};
            case (r_state)
                c_idle: begin
                    r_baud_cnt <= c_cnt_zero;
                    r_bit_cnt  <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= c_start;
                    end
                end
                c_start: begin
                    if (w_sample) begin
                        r_baud_cnt <= c_cnt_zero;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= w_rx_s ? c_idle : c_data;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                c_data: begin
                    if (w_sample) begin
                        r_baud_cnt <= c_cnt_zero;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_parity;
`else
                            r_state <= c_stop;
`endif
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_parity: begin
                    if (w_sample) begin
                        r_baud_cnt <= c_cnt_zero;
                        r_state    <= c_stop;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`endif
                c_stop: begin
                    if (w_sample) begin
                        r_baud_cnt <= c_cnt_zero;
                        r_state    <= c_idle;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_baud_cnt <= c_cnt_zero;
                    r_bit_cnt  <= 3'd0;
                    r_state    <= c_idle;
                end
            endcase
        end
    end

    // Stop-bit outcome priority: framing, then parity, then overrun, else accept.
    assign w_stop_sample = w_sample && (r_state == c_stop);
    assign w_good_stop   = w_stop_sample && w_rx_s && !w_par_err;

    assign Shift_ena   = w_sample && (r_state == c_data);
    assign Shift_din   = Shift_ena && w_rx_s;
    assign Frame_err   = w_stop_sample && !w_rx_s;
    assign Parity_err  = w_stop_sample && w_rx_s && w_par_err;
    assign Data_valid  = w_good_stop && !Fifo_full;
    assign Overrun_err = w_good_stop && Fifo_full;
    assign Busy        = (r_state != c_idle);

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: CLK_DIV, 868, Clk cycles per UART bit period (integer, minimum 4).
REQ-002 SHALL have port: Clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: RxD  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: Fifo_full  input  1  downstream FIFO cannot accept a byte.
REQ-006 SHALL have port: Shift_ena  output  1  one-cycle enable to the 8-bit RX shift register.
REQ-007 SHALL have port: Shift_din  output  1  sampled data bit, valid while Shift_ena=1.
REQ-008 SHALL have port: Data_valid  output  1  one-cycle FIFO write strobe, byte complete in shift register.
REQ-009 SHALL have port: Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: Frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port: Overrun_err  output  1  one-cycle pulse, good byte dropped because Fifo_full=1.
REQ-012 SHALL have port: Parity_err  output  1  one-cycle pulse, parity mismatch (see REQ-030).

Function
REQ-013 SHALL pass RxD through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: rx_s=0 in a cycle t0 -> START, baud counter cleared to 0.
REQ-016 START: at cycle t0+CLK_DIV/2 (integer division), sample rx_s; 1 -> IDLE (false start, no outputs), 0 -> DATA with baud counter and bit counter cleared.
REQ-017 DATA: every CLK_DIV cycles after the start-bit sample, sample rx_s; in that same cycle Shift_ena=1 and Shift_din=rx_s.
REQ-018 DATA: exactly 8 Shift_ena pulses per frame, LSB first; after the 8th, -> PARITY if enabled, else STOP.
REQ-019 STOP: sample rx_s CLK_DIV cycles after the last data (or parity) sample.
REQ-020 STOP sample=0 -> Frame_err=1 for that cycle, Data_valid=0.
REQ-021 STOP sample=1, no pending parity error, Fifo_full=0 -> Data_valid=1 for that cycle.
REQ-022 STOP sample=1, no pending parity error, Fifo_full=1 -> Overrun_err=1, Data_valid=0.
REQ-023 Frame error takes precedence over parity and overrun; at most one error pulse per frame.
REQ-024 STOP always -> IDLE next cycle; a start edge is detectable from the cycle after the stop sample (half stop bit).
REQ-025 Shift_ena, Data_valid and all error outputs SHALL never be high in the same cycle as each other, except none.
REQ-026 Baud counter width SHALL be $clog2(CLK_DIV); it SHALL never wrap mid-bit (reload at each sample).

Reset
REQ-027 Rst=1 at any clock edge SHALL force state IDLE, counters 0, synchronizer flops 1, all outputs 0, regardless of state.
REQ-028 Reset mid-frame SHALL abort the frame with no Data_valid or error pulse; the next full frame after Rst=0 is received normally.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-030 With UART_RX_PARITY_EN defined: PARITY state samples one bit CLK_DIV cycles after the 8th data sample; even parity over 8 data bits + parity bit; mismatch -> Parity_err=1 in the STOP sample cycle (if stop=1) and Data_valid=0; frame length 11 bits.
REQ-031 Without UART_RX_PARITY_EN: no PARITY state, Parity_err tied 0, frame length 10 bits.

Verification
REQ-032 CLK_DIV=16, frame 0xA5 (8N1) -> Shift_ena 8 pulses 16 cycles apart, Shift_din 1,0,1,0,0,1,0,1, one Data_valid at stop sample, no errors.
REQ-033 CLK_DIV=16, RxD low for 4 cycles then high -> Busy pulses, no Shift_ena, back to IDLE at t0+8.
REQ-034 CLK_DIV=16, 0x3C with stop bit 0 -> Frame_err one pulse, Data_valid never asserted.
REQ-035 CLK_DIV=16, 0x3C valid frame, Fifo_full=1 -> Overrun_err one pulse, Data_valid=0; repeat with Fifo_full=0 -> Data_valid.
REQ-036 UART_RX_PARITY_EN, 0x03 with parity bit 1 -> Parity_err one pulse, no Data_valid; parity bit 0 -> Data_valid.
REQ-037 Rst=1 for 1 cycle after 4th Shift_ena of 0xA5 -> all outputs 0, IDLE; following frame 0x5A received, one Data_valid.
